alu_issue_queue: RTL and testbench

//  Issue stage directly upstream of configurable_alu: buffers ALU requests {op, a, b, fwd, tag} in a DEPTH-entry FIFO.

---
 rtl/alu_issue_queue_pkg.sv | 18 +
 rtl/alu_pkg.sv | 13 +
 rtl/alu_issue_queue_if.sv | 43 ++++
 rtl/alu_issue_queue_issue_fifo.sv | 51 +++++
 rtl/configurable_alu.sv | 23 ++
 rtl/alu_issue_queue.sv | 131 +++++++++++++
 tb/tb_alu_issue_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Issue-queue local types: output slot state encoding and default sizing.
package alu_issue_queue_pkg;

  // Output slot occupancy; PRESENT means out_* hold a valid op.
  typedef enum logic {
    SLOT_EMPTY   = 1'b0,
    SLOT_PRESENT = 1'b1
  } slot_state_e;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_W = 4;

  // Occupancy counter width for a FIFO of the given depth (counts 0..depth).
  function automatic int level_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and datapath widths used by the
// issue queue and the ALU it feeds.
package alu_pkg;

  localparam int ALU_OP_W   = 2;
  localparam int ALU_DATA_W = 32;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] OP_AND = 2'b10;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request/issue bus of the ALU issue queue.
//
// Handshake rules (both sides): a transfer happens on the rising edge where
// valid & ready are both high. A producer holding valid must keep its payload
// stable until the transfer. in_ready never depends on in_valid or out_ready;
// out_valid and out_* are registered and stay stable while out_ready is low.
interface alu_issue_queue_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_fwd_a;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_op;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] alu_result;

  logic [LVL_W-1:0]  level;

  // Environment side: issues requests, consumes ops, returns the ALU result.
  modport master (
    output in_valid, in_op, in_a, in_b, in_fwd_a, in_tag, out_ready, alu_result,
    input  in_ready, out_valid, out_op, out_a, out_b, out_tag, level
  );

  // Queue side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_fwd_a, in_tag, out_ready, alu_result,
    output in_ready, out_valid, out_op, out_a, out_b, out_tag, level
  );
endinterface

// File: rtl/alu_issue_queue_issue_fifo.sv
// Synchronous FIFO of packed issue entries with occupancy output.
// Head is read combinationally; the caller guarantees no push when full and
// no pop when empty. flush clears pointers and occupancy at the next edge.
module issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Entry storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/configurable_alu.sv
// Combinational two-operand ALU fed by the issue queue's output slot.
module configurable_alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op_code,
  input  logic [ALU_DATA_W-1:0] operand_a,
  input  logic [ALU_DATA_W-1:0] operand_b,
  output logic [ALU_DATA_W-1:0] result
);

  // Select the operation; ADD/SUB wrap modulo 2^ALU_DATA_W.
  always_comb begin
    result = '0;
    case (op_code)
      OP_ADD:  result = operand_a + operand_b;
      OP_SUB:  result = operand_a - operand_b;
      OP_AND:  result = operand_a & operand_b;
      OP_OR:   result = operand_a | operand_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: FIFO of requests feeding a registered output slot that
// drives the ALU. Operand A of a forwarded entry is resolved when it is loaded
// into the slot, from the result of the op issued just before it.
module alu_issue_queue
  import alu_pkg::*;
  import alu_issue_queue_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_issue_queue_if.slave    bus,
  output slot_state_e         dbg_state
);
  localparam int LVL_W = level_w(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                fwd;
    logic [TAG_W-1:0]    tag;
  } entry_t;

  slot_state_e         state_q;
  slot_state_e         state_d;
  entry_t              in_entry;
  entry_t              head;
  logic [LVL_W-1:0]    level;
  logic                push;
  logic                load;
  logic                handshake;
  logic                out_valid_w;
  logic                fifo_nonempty;
  logic [DATA_W-1:0]   fwd_reg;
  logic [DATA_W-1:0]   fwd_src;
  logic [DATA_W-1:0]   a_resolved;
  logic [ALU_OP_W-1:0] slot_op;
  logic [DATA_W-1:0]   slot_a;
  logic [DATA_W-1:0]   slot_b;
  logic [TAG_W-1:0]    slot_tag;

  // A pop in the same cycle never re-opens in_ready: it only looks at level.
  assign bus.in_ready  = (level < DEPTH_L) & ~flush;
  assign push          = bus.in_valid & bus.in_ready;
  assign fifo_nonempty = (level != '0);

  assign in_entry = '{op: bus.in_op, a: bus.in_a, b: bus.in_b,
                      fwd: bus.in_fwd_a, tag: bus.in_tag};

  issue_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (in_entry),
    .pop   (load),
    .rdata (head),
    .level (level)
  );

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SLOT_EMPTY;
    else        state_q <= state_d;
  end

  // Slot next state: flush wins, a load always leaves the slot occupied.
  always_comb begin
    state_d = state_q;
    if (flush)                                              state_d = SLOT_EMPTY;
    else if (load)                                          state_d = SLOT_PRESENT;
    else if ((state_q == SLOT_PRESENT) && bus.out_ready)    state_d = SLOT_EMPTY;
  end

  // Slot outputs: valid flag, consume handshake and load decision.
  always_comb begin
    out_valid_w = (state_q == SLOT_PRESENT);
    handshake   = out_valid_w & bus.out_ready;
    load        = fifo_nonempty & (~out_valid_w | bus.out_ready) & ~flush;
  end

  // Forward source: the result being consumed this cycle bypasses fwd_reg.
  always_comb begin
    fwd_src    = handshake ? bus.alu_result : fwd_reg;
    a_resolved = head.fwd ? fwd_src : head.a;
  end

  // Slot payload: captured on load, held otherwise so out_* stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_op  <= '0;
      slot_a   <= '0;
      slot_b   <= '0;
      slot_tag <= '0;
    end else if (flush) begin
      slot_op  <= '0;
      slot_a   <= '0;
      slot_b   <= '0;
      slot_tag <= '0;
    end else if (load) begin
      slot_op  <= head.op;
      slot_a   <= a_resolved;
      slot_b   <= head.b;
      slot_tag <= head.tag;
    end
  end

  // Forward register: result of the most recently consumed op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fwd_reg <= '0;
    else if (flush)     fwd_reg <= '0;
    else if (handshake) fwd_reg <= bus.alu_result;
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_op    = slot_op;
  assign bus.out_a     = slot_a;
  assign bus.out_b     = slot_b;
  assign bus.out_tag   = slot_tag;
  assign bus.level     = level;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue driving configurable_alu from the output slot.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          fwd;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    req_t          req;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_res;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  slot_state_e dbg_state;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH)) bus ();

  alu_issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  configurable_alu u_alu (
    .op_code   (bus.out_op),
    .operand_a (bus.out_a),
    .operand_b (bus.out_b),
    .result    (bus.alu_result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // pend_q: accepted requests not yet in the slot; m_slot: op being presented;
  // m_last: result of the last consumed op (value a forwarded entry receives).
  req_t          pend_q[$];
  logic [TW-1:0] exp_q[$];
  logic          m_slot_v = 1'b0;
  req_t          m_slot   = '0;
  logic [DW-1:0] m_last   = '0;
  logic [TW-1:0] got_tag_q[$];
  logic [DW-1:0] got_a_q[$];
  logic [DW-1:0] got_res_q[$];

  logic          c_hs, c_ld, c_pu, c_rdy;
  logic [DW-1:0] c_res;
  req_t          c_it;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
      m_slot_v = 1'b0;
      m_slot   = '0;
      m_last   = '0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_level", bus.level, 0);
      check("rst_out_a", bus.out_a, 0);
    end else begin
      c_rdy = (pend_q.size() < DEPTH) && !flush;
      check("in_ready", bus.in_ready, c_rdy);
      check("level", bus.level, pend_q.size());
      check("out_valid", bus.out_valid, m_slot_v);
      c_res = alu_ref(m_slot.op, m_slot.a, m_slot.b);
      if (m_slot_v) begin
        check("out_op", bus.out_op, m_slot.op);
        check("out_a", bus.out_a, m_slot.a);
        check("out_b", bus.out_b, m_slot.b);
        check("out_tag", bus.out_tag, m_slot.tag);
        check("alu_result", bus.alu_result, c_res);
      end
      c_hs = m_slot_v && bus.out_ready;
      c_ld = (pend_q.size() > 0) && (!m_slot_v || bus.out_ready);
      c_pu = bus.in_valid && c_rdy;
      if (flush) begin
        pend_q.delete();
        exp_q.delete();
        m_slot_v = 1'b0;
        m_last   = '0;
      end else begin
        if (c_hs) begin
          got_tag_q.push_back(bus.out_tag);
          got_a_q.push_back(bus.out_a);
          got_res_q.push_back(bus.alu_result);
          check("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("sb_tag", bus.out_tag, exp_q.pop_front());
          m_last   = c_res;
          m_slot_v = 1'b0;
        end
        if (c_ld) begin
          c_it = pend_q.pop_front();
          if (c_it.fwd) c_it.a = m_last;
          m_slot   = c_it;
          m_slot_v = 1'b1;
        end
        if (c_pu) begin
          pend_q.push_back('{op: bus.in_op, a: bus.in_a, b: bus.in_b,
                             fwd: bus.in_fwd_a, tag: bus.in_tag});
          exp_q.push_back(bus.in_tag);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(req_t r);
    bus.in_op    = r.op;
    bus.in_a     = r.a;
    bus.in_b     = r.b;
    bus.in_fwd_a = r.fwd;
    bus.in_tag   = r.tag;
  endtask

  function automatic req_t mk(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                              logic fwd, logic [TW-1:0] tag);
    return '{op: op, a: a, b: b, fwd: fwd, tag: tag};
  endfunction

  task automatic push_wait(req_t r, int budget);
    bit ok;
    bit acc;
    ok = 1'b0;
    set_req(r);
    bus.in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic wait_hs(int n, int budget);
    for (int i = 0; i < budget && got_tag_q.size() < n; i++) tick();
    check("hs_count", got_tag_q.size(), n);
  endtask

  task automatic clear_got();
    got_tag_q.delete();
    got_a_q.delete();
    got_res_q.delete();
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[8];
  req_t src[20];
  int   idx;
  bit   acc;

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.in_fwd_a = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;

    vecs[0] = '{mk(2'b00, 32'd5, 32'd3, 1'b0, 4'd1), 32'd5, 32'd8};
    vecs[1] = '{mk(2'b00, 32'd10, 32'd20, 1'b0, 4'd2), 32'd10, 32'd30};
    vecs[2] = '{mk(2'b01, 32'hDEAD, 32'd7, 1'b1, 4'd3), 32'd30, 32'd23};
    vecs[3] = '{mk(2'b11, 32'd0, 32'h100, 1'b1, 4'd4), 32'd23, 32'h117};
    vecs[4] = '{mk(2'b10, 32'hF0F0, 32'hFF00, 1'b0, 4'd5), 32'hF0F0, 32'hF000};
    vecs[5] = '{mk(2'b01, 32'd0, 32'd1, 1'b0, 4'd6), 32'd0, 32'hFFFF_FFFF};
    vecs[6] = '{mk(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd7), 32'hFFFF_FFFF, 32'd1};
    vecs[7] = '{mk(2'b11, 32'h5555, 32'd0, 1'b1, 4'd8), 32'd1, 32'd1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_state", dbg_state == SLOT_EMPTY, 1);
    tick();

    // Single op latency: push in cycle 0, presented in cycle 2.
    bus.out_ready = 1'b1;
    set_req(mk(2'b00, 32'd5, 32'd3, 1'b0, 4'd1));
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_c0_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", bus.out_valid, 0);
    check("lat_c1_level", bus.level, 1);
    @(negedge clk);
    check("lat_c2_valid", bus.out_valid, 1);
    check("lat_c2_op", bus.out_op, 0);
    check("lat_c2_a", bus.out_a, 5);
    check("lat_c2_b", bus.out_b, 3);
    check("lat_c2_tag", bus.out_tag, 1);
    check("lat_c2_res", bus.alu_result, 8);
    tick();

    // Table: one op at a time, forwarded entries chain through fwd_reg.
    for (int v = 0; v < 8; v++) begin
      clear_got();
      push_wait(vecs[v].req, 5);
      wait_hs(1, 10);
      if (got_tag_q.size() > 0) begin
        check($sformatf("vec%0d_a", v), got_a_q[0], vecs[v].exp_a);
        check($sformatf("vec%0d_res", v), got_res_q[0], vecs[v].exp_res);
        check($sformatf("vec%0d_tag", v), got_tag_q[0], vecs[v].req.tag);
      end
    end

    // Back-to-back forward chain exercising the same-cycle bypass.
    clear_got();
    bus.in_valid = 1'b1;
    set_req(mk(2'b00, 32'd10, 32'd20, 1'b0, 4'd2)); tick();
    set_req(mk(2'b01, 32'd0, 32'd7, 1'b1, 4'd3));   tick();
    set_req(mk(2'b11, 32'd0, 32'h100, 1'b1, 4'd4)); tick();
    bus.in_valid = 1'b0;
    wait_hs(3, 20);
    if (got_tag_q.size() == 3) begin
      check("chain_a1", got_a_q[1], 30);
      check("chain_a2", got_a_q[2], 23);
      check("chain_res1", got_res_q[1], 23);
      check("chain_res2", got_res_q[2], 32'h117);
    end

    // Full: slot plus DEPTH entries, sixth request held off.
    clear_got();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_wait(mk(2'(i % 4), 32'(100 + i), 32'(i), 1'b0, 4'(i)), 5);
    set_req(mk(2'b00, 32'd200, 32'd1, 1'b0, 4'd5));
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("full_level", bus.level, 4);
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_valid", bus.out_valid, 1);
    check("full_out_tag", bus.out_tag, 0);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_no_reopen", bus.in_ready, 0);
    tick();
    @(negedge clk);
    check("full_reopen", bus.in_ready, 1);
    check("full_level_after_pop", bus.level, 3);
    tick();
    bus.in_valid = 1'b0;
    wait_hs(6, 30);
    for (int i = 0; i < 6 && i < got_tag_q.size(); i++) check($sformatf("full_order%0d", i), got_tag_q[i], i);

    // Flush with a simultaneous push; forwarded op afterwards sees 0.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_wait(mk(2'b00, 32'(i), 32'(i), 1'b0, 4'(i)), 5);
    set_req(mk(2'b00, 32'd9, 32'd9, 1'b0, 4'd9));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_level", bus.level, 0);
    tick();
    clear_got();
    bus.out_ready = 1'b1;
    push_wait(mk(2'b01, 32'h1234, 32'd5, 1'b1, 4'd10), 5);
    wait_hs(1, 10);
    if (got_tag_q.size() > 0) begin
      check("flush_fwd_a", got_a_q[0], 0);
      check("flush_fwd_tag", got_tag_q[0], 10);
      check("flush_fwd_res", got_res_q[0], 32'hFFFF_FFFB);
    end

    // Reset asserted mid-stream clears outputs without a clock edge.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_wait(mk(2'b00, 32'h55, 32'(i), 1'b0, 4'(i + 1)), 5);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_level", bus.level, 0);
    check("async_rst_a", bus.out_a, 0);
    check("async_rst_tag", bus.out_tag, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", bus.in_ready, 1);
    tick();

    // Random traffic with wrapping tags and random backpressure.
    for (int round = 0; round < 3; round++) begin
      clear_got();
      for (int i = 0; i < 20; i++)
        src[i] = mk(2'($urandom_range(0, 3)), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), 4'(i % 16));
      idx = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        if (idx < 20) begin
          set_req(src[idx]);
          bus.in_valid = 1'($urandom_range(0, 1));
        end else begin
          bus.in_valid = 1'b0;
        end
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        tick();
        if (acc) idx++;
        if (idx == 20 && got_tag_q.size() == 20) break;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("rand_accepted", idx, 20);
      check("rand_consumed", got_tag_q.size(), 20);
      check("rand_sb_empty", exp_q.size(), 0);
      for (int i = 0; i < 20 && i < got_tag_q.size(); i++)
        check($sformatf("rand%0d_tag%0d", round, i), got_tag_q[i], i % 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
